// File: rtl/cpu_pkg.sv
// Shared bus encodings, bridge states and error-bit indices for the cpu external bus.
package cpu_pkg;

  localparam int BITS = 8;

  localparam logic PHASE_ADDR = 1'b0;
  localparam logic PHASE_DATA = 1'b1;
  localparam logic FETCH_ROM  = 1'b0;
  localparam logic FETCH_RAM  = 1'b1;

  localparam int ERR_W       = 3;
  localparam int ERR_PROTO   = 0;
  localparam int ERR_ROMWR   = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACCESS,
    ST_RESP
  } bridge_state_e;

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter: clear wins over enable, terminal flag when the count reaches TIMEOUT-1.
module wait_timer #(
  parameter int TO_BITS = 8,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [TO_BITS-1:0] TERM = TO_BITS'(TIMEOUT - 1);

  logic [TO_BITS-1:0] count_q;
  logic [TO_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TO_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == TERM);

endmodule

// File: rtl/mem_bridge.sv
// Splits the cpu's two-phase bus into a flat ROM/RAM port with chip-selects, wait states,
// a bounded timeout and sticky protocol/error flags. All outputs come straight from flops.
module mem_bridge
  import cpu_pkg::*;
#(
  parameter int BITS    = cpu_pkg::BITS,
  parameter int TIMEOUT = 16,
  parameter int TO_BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpu_valid,
  input  logic            cpu_addr_data,
  input  logic            cpu_rom_ram,
  input  logic            cpu_we,
  input  logic [BITS-1:0] cpu_wdata,
  output logic [BITS-1:0] cpu_rdata,
  output logic            cpu_rdata_valid,
  output logic            cpu_busy,
  output logic [BITS-1:0] mem_addr,
  output logic [BITS-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_rom_cs,
  output logic            mem_ram_cs,
  input  logic [BITS-1:0] mem_rdata,
  input  logic            mem_ready,
  input  logic            err_clear,
  output logic [2:0]      err_flags
);

  bridge_state_e   state_q;
  logic            target_q;
  logic [BITS-1:0] mem_addr_q;
  logic [BITS-1:0] mem_wdata_q;
  logic [BITS-1:0] cpu_rdata_q;
  logic            mem_we_q;
  logic            rom_cs_q;
  logic            ram_cs_q;
  logic            rdata_valid_q;
  logic            busy_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;

  logic timer_clear;
  logic timer_enable;
  logic timer_term;
  logic err_proto;
  logic err_romwr;
  logic err_timeout;

  // The counter only runs while waiting on memory; any other state holds it at zero.
  assign timer_clear  = (state_q != ST_ACCESS);
  assign timer_enable = (state_q == ST_ACCESS) && !mem_ready;

  wait_timer #(
    .TO_BITS (TO_BITS),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (timer_clear),
    .enable_i   (timer_enable),
    .terminal_o (timer_term)
  );

  assign err_proto   = cpu_valid && (state_q == ST_IDLE) && (cpu_addr_data == PHASE_DATA);
  assign err_romwr   = cpu_valid && (state_q == ST_ADDR) && (cpu_addr_data == PHASE_DATA)
                       && (target_q == FETCH_ROM) && cpu_we;
  assign err_timeout = (state_q == ST_ACCESS) && !mem_ready && timer_term;

  // A new error on the same edge as err_clear must survive the clear.
  always_comb begin
    err_d = err_clear ? '0 : err_q;
    if (err_proto)   err_d[ERR_PROTO]   = 1'b1;
    if (err_romwr)   err_d[ERR_ROMWR]   = 1'b1;
    if (err_timeout) err_d[ERR_TIMEOUT] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      target_q      <= FETCH_ROM;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_rdata_q   <= '0;
      mem_we_q      <= 1'b0;
      rom_cs_q      <= 1'b0;
      ram_cs_q      <= 1'b0;
      rdata_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= '0;
    end else begin
      rdata_valid_q <= 1'b0;
      err_q         <= err_d;
      unique case (state_q)
        ST_IDLE: begin
          if (cpu_valid && (cpu_addr_data == PHASE_ADDR)) begin
            mem_addr_q <= cpu_wdata;
            target_q   <= cpu_rom_ram;
            state_q    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (cpu_valid) begin
            if (cpu_addr_data == PHASE_ADDR) begin
              mem_addr_q <= cpu_wdata;
              target_q   <= cpu_rom_ram;
            end else if ((target_q == FETCH_ROM) && cpu_we) begin
              cpu_rdata_q   <= '0;
              rdata_valid_q <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              mem_wdata_q <= cpu_wdata;
              mem_we_q    <= cpu_we;
              rom_cs_q    <= (target_q == FETCH_ROM);
              ram_cs_q    <= (target_q == FETCH_RAM);
              busy_q      <= 1'b1;
              state_q     <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          // Ready is tested first so a completion on the terminal cycle is not an error.
          if (mem_ready) begin
            cpu_rdata_q   <= mem_we_q ? '0 : mem_rdata;
            mem_we_q      <= 1'b0;
            rom_cs_q      <= 1'b0;
            ram_cs_q      <= 1'b0;
            rdata_valid_q <= 1'b1;
            state_q       <= ST_RESP;
          end else if (timer_term) begin
            cpu_rdata_q   <= '1;
            mem_we_q      <= 1'b0;
            rom_cs_q      <= 1'b0;
            ram_cs_q      <= 1'b0;
            rdata_valid_q <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata       = cpu_rdata_q;
  assign cpu_rdata_valid = rdata_valid_q;
  assign cpu_busy        = busy_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_we          = mem_we_q;
  assign mem_rom_cs      = rom_cs_q;
  assign mem_ram_cs      = ram_cs_q;
  assign err_flags       = err_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: directed cases then randomized transactions against a
// transaction-level model; a monitor pops expectations whenever a response strobe appears.
module tb_mem_bridge;

  localparam int TB_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_valid;
  logic       cpu_addr_data;
  logic       cpu_rom_ram;
  logic       cpu_we;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_rdata_valid;
  logic       cpu_busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_rom_cs;
  logic       mem_ram_cs;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       err_clear;
  logic [2:0] err_flags;

  typedef struct {
    logic [7:0] rdata;
    logic [2:0] flags;
    int         csCycles;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       isRam;
  } exp_t;

  exp_t       expQ[$];
  int         tests = 0;
  int         fails = 0;
  int         waitCfg = 0;
  logic [7:0] rdataCfg = 8'h00;
  logic [2:0] flagsModel = 3'b000;

  mem_bridge #(
    .BITS    (8),
    .TIMEOUT (TB_TIMEOUT),
    .TO_BITS (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cpu_valid       (cpu_valid),
    .cpu_addr_data   (cpu_addr_data),
    .cpu_rom_ram     (cpu_rom_ram),
    .cpu_we          (cpu_we),
    .cpu_wdata       (cpu_wdata),
    .cpu_rdata       (cpu_rdata),
    .cpu_rdata_valid (cpu_rdata_valid),
    .cpu_busy        (cpu_busy),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .mem_rom_cs      (mem_rom_cs),
    .mem_ram_cs      (mem_ram_cs),
    .mem_rdata       (mem_rdata),
    .mem_ready       (mem_ready),
    .err_clear       (err_clear),
    .err_flags       (err_flags)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: ready rises on the (waitCfg+1)-th chip-select cycle; noise while idle.
  initial begin
    int k = 0;
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (mem_rom_cs || mem_ram_cs) begin
        k++;
        mem_ready = (k == waitCfg + 1);
        mem_rdata = rdataCfg;
      end else begin
        k = 0;
        mem_ready = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Monitor: checks the memory side against the head expectation and pops on each response.
  initial begin
    int   csCycles = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      checkOutput("csExclusive", 32'(mem_rom_cs & mem_ram_cs), 0);
      if (!reset) begin
        csCycles = 0;
      end else begin
        if (mem_rom_cs || mem_ram_cs) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL spuriousCs: chip-select high with no access pending at %0t", $time);
          end else begin
            e = expQ[0];
            if (csCycles == 0) begin
              checkOutput("memAddr", 32'(mem_addr), 32'(e.addr));
              checkOutput("memWdata", 32'(mem_wdata), 32'(e.wdata));
              checkOutput("ramCs", 32'(mem_ram_cs), 32'(e.isRam));
              checkOutput("romCs", 32'(mem_rom_cs), 32'(!e.isRam));
            end
            checkOutput("memWe", 32'(mem_we), 32'(e.we));
          end
          csCycles++;
        end
        if (cpu_rdata_valid) begin
          if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL spuriousValid: response with nothing expected at %0t", $time);
          end else begin
            e = expQ.pop_front();
            checkOutput("rdata", 32'(cpu_rdata), 32'(e.rdata));
            checkOutput("errFlags", 32'(err_flags), 32'(e.flags));
            checkOutput("csCycles", 32'(csCycles), 32'(e.csCycles));
          end
          csCycles = 0;
        end
      end
    end
  end

  task automatic issuePhase(input logic phase, input logic isRam, input logic we,
                            input logic [7:0] data, input logic clr);
    @(negedge clk);
    cpu_valid     = 1'b1;
    cpu_addr_data = phase;
    cpu_rom_ram   = isRam;
    cpu_we        = we;
    cpu_wdata     = data;
    err_clear     = clr;
  endtask

  task automatic finishTxn(input logic isRam, input logic [7:0] addr, input logic we,
                           input logic [7:0] wdata, input logic [7:0] rdata, input int w,
                           input logic clr);
    exp_t e;
    int   lat = 0;
    int   expLat;
    if (clr) flagsModel = 3'b000;
    e.addr  = addr;
    e.wdata = wdata;
    e.we    = we;
    e.isRam = isRam;
    if (!isRam && we) begin
      e.rdata = 8'h00;
      flagsModel[1] = 1'b1;
      e.csCycles = 0;
      expLat = 1;
    end else if (w >= TB_TIMEOUT) begin
      e.rdata = 8'hFF;
      flagsModel[2] = 1'b1;
      e.csCycles = TB_TIMEOUT;
      expLat = TB_TIMEOUT + 1;
    end else begin
      e.rdata = we ? 8'h00 : rdata;
      e.csCycles = w + 1;
      expLat = w + 2;
    end
    e.flags  = flagsModel;
    waitCfg  = w;
    rdataCfg = rdata;
    expQ.push_back(e);
    issuePhase(1'b1, isRam, we, wdata, clr);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      err_clear = 1'b0;
      checkOutput("busyDuringTxn", 32'(cpu_busy), 1);
      if (cpu_rdata_valid) break;
      if ($urandom_range(0, 1) == 1) begin
        cpu_valid     = 1'b1;
        cpu_addr_data = 1'($urandom);
        cpu_rom_ram   = 1'($urandom);
        cpu_we        = 1'($urandom);
        cpu_wdata     = 8'($urandom);
      end else begin
        cpu_valid = 1'b0;
      end
    end
    cpu_valid = 1'b0;
    checkOutput("latency", 32'(lat), 32'(expLat));
    @(negedge clk);
    checkOutput("validPulse", 32'(cpu_rdata_valid), 0);
    checkOutput("busyIdle", 32'(cpu_busy), 0);
  endtask

  task automatic applyStimulus(input logic isRam, input logic [7:0] addr, input logic we,
                               input logic [7:0] wdata, input logic [7:0] rdata, input int w,
                               input logic clr);
    issuePhase(1'b0, isRam, 1'b0, addr, 1'b0);
    finishTxn(isRam, addr, we, wdata, rdata, w, clr);
  endtask

  task automatic clearFlags();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear  = 1'b0;
    flagsModel = 3'b000;
    checkOutput("errClear", 32'(err_flags), 0);
  endtask

  task automatic protoError();
    issuePhase(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
    @(negedge clk);
    cpu_valid = 1'b0;
    flagsModel[0] = 1'b1;
    checkOutput("protoFlag", 32'(err_flags), 32'(flagsModel));
    checkOutput("protoBusy", 32'(cpu_busy), 0);
  endtask

  initial begin
    reset         = 1'b0;
    cpu_valid     = 1'b0;
    cpu_addr_data = 1'b0;
    cpu_rom_ram   = 1'b0;
    cpu_we        = 1'b0;
    cpu_wdata     = 8'h00;
    err_clear     = 1'b0;

    #2;
    checkOutput("rstRdata", 32'(cpu_rdata), 0);
    checkOutput("rstValid", 32'(cpu_rdata_valid), 0);
    checkOutput("rstBusy", 32'(cpu_busy), 0);
    checkOutput("rstMemAddr", 32'(mem_addr), 0);
    checkOutput("rstMemWdata", 32'(mem_wdata), 0);
    checkOutput("rstMemWe", 32'(mem_we), 0);
    checkOutput("rstRomCs", 32'(mem_rom_cs), 0);
    checkOutput("rstRamCs", 32'(mem_ram_cs), 0);
    checkOutput("rstErr", 32'(err_flags), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 8'hA5, 0, 1'b0);
    applyStimulus(1'b1, 8'h10, 1'b1, 8'h77, 8'h00, 3, 1'b0);
    applyStimulus(1'b0, 8'h05, 1'b1, 8'h42, 8'h00, 0, 1'b0);
    clearFlags();
    applyStimulus(1'b1, 8'h20, 1'b0, 8'h00, 8'h5A, 99, 1'b0);
    applyStimulus(1'b1, 8'h21, 1'b0, 8'h00, 8'hC3, 3, 1'b0);
    clearFlags();
    protoError();
    issuePhase(1'b0, 1'b0, 1'b0, 8'h11, 1'b0);
    issuePhase(1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
    finishTxn(1'b1, 8'h22, 1'b0, 8'h00, 8'h9E, 1, 1'b0);
    applyStimulus(1'b0, 8'h05, 1'b1, 8'h13, 8'h00, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic       isRam;
      logic       we;
      logic [7:0] addr;
      isRam = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom);
      addr  = 8'($urandom);
      if ($urandom_range(0, 9) == 0) protoError();
      if ($urandom_range(0, 3) == 0) issuePhase(1'b0, 1'($urandom), 1'b0, 8'($urandom), 1'b0);
      issuePhase(1'b0, isRam, 1'b0, addr, 1'b0);
      finishTxn(isRam, addr, we, 8'($urandom), 8'($urandom), $urandom_range(0, 5),
                ($urandom_range(0, 3) == 0));
    end

    protoError();
    begin
      exp_t e;
      e.rdata = 8'h00;
      e.flags = flagsModel;
      e.csCycles = 0;
      e.addr  = 8'h44;
      e.wdata = 8'h99;
      e.we    = 1'b1;
      e.isRam = 1'b1;
      expQ.push_back(e);
    end
    waitCfg = 99;
    issuePhase(1'b0, 1'b1, 1'b0, 8'h44, 1'b0);
    issuePhase(1'b1, 1'b1, 1'b1, 8'h99, 1'b0);
    @(negedge clk);
    cpu_valid = 1'b0;
    @(negedge clk);
    checkOutput("preResetCs", 32'(mem_ram_cs), 1);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRamCs", 32'(mem_ram_cs), 0);
    checkOutput("asyncWe", 32'(mem_we), 0);
    checkOutput("asyncValid", 32'(cpu_rdata_valid), 0);
    checkOutput("asyncErr", 32'(err_flags), 0);
    checkOutput("asyncBusy", 32'(cpu_busy), 0);
    checkOutput("asyncAddr", 32'(mem_addr), 0);
    expQ.delete();
    flagsModel = 3'b000;
    @(negedge clk);
    #2 reset = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 8'hA5, 0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queueDrained", 32'(expQ.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
